silence_gate_ctrl: RTL and testbench
====================================

Name: silence_gate_ctrl

Overview:
- Noise-gate controller that sequences the audio path from the silence flag produced by the frequency-machine silence detector.
- On sustained silence it holds, fades the signal out to mute, and fades back in when signal returns.
- Applies the resulting gain to the sample stream. Sits directly after the silence detector, before the frequency-machine core.

Parameters:
- DW, 16, sample width (signed two's complement).
- GAIN_W, 8, gain width; unity gain GMAX = 2^GAIN_W-1.
- HOLD_SAMPLES, 4410, sample ticks of continuous silence before fade-out starts; range 1..65535.
- RAMP_STEP, 1, gain change per sample tick during fades; range 1..GMAX.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous active-high reset.
- sample_tick_i  in  1  one-clock strobe, new sample on data_i.
- enable_i  in  1  gate enable; 0 forces pass-through.
- silence_i  in  1  silence flag from detector, level-sensitive.
- data_i  in  DW  input sample, signed.
- data_o  out  DW  gated sample, signed.
- sample_tick_o  out  1  strobe, data_o updated.
- gain_o  out  GAIN_W  current gain.
- muted_o  out  1  high while in CLOSED.
- state_o  out  3  state encoding, for debug.

Behaviour:
- Reset (async, any time including mid-fade):
  - state OPEN, gain GMAX, hold counter 0.
  - data_o 0, sample_tick_o 0, muted_o 0.
- State and gain update only on cycles with sample_tick_i=1. Between ticks everything holds.
- State encoding: OPEN=0, HOLD=1, FADE_OUT=2, CLOSED=3, FADE_IN=4.
- OPEN: gain GMAX. On silence_i=1, go to HOLD and clear the counter.
- HOLD: counter increments per tick.
  - silence_i=0 goes to OPEN.
  - Counter == HOLD_SAMPLES-1 with silence_i=1 goes to FADE_OUT.
  - HOLD_SAMPLES=1 means the next tick enters FADE_OUT.
- FADE_OUT:
  - silence_i=0 goes to FADE_IN with no gain change that tick.
  - Otherwise, if gain <= RAMP_STEP, gain becomes 0 and state goes to CLOSED; else gain decreases by RAMP_STEP.
- CLOSED: gain 0. silence_i=0 goes to FADE_IN.
- FADE_IN: silence_i is ignored. If gain >= GMAX-RAMP_STEP, gain becomes GMAX and state goes to OPEN; else gain increases by RAMP_STEP.
- Gain arithmetic is saturating and never wraps.
- enable_i=0: on the next clock edge (tick not required), state goes to OPEN, gain GMAX, counter 0. enable_i overrides silence_i on the same cycle.
- Datapath:
  - On sample_tick_i, compute the full-precision signed product data_i * {0,gain} (DW+GAIN_W bits), then arithmetic-shift right by GAIN_W and register the result to data_o.
  - The gain used is the registered gain before this tick's update.
  - Exception: gain == GMAX gives data_o = data_i exactly (unity bypass).
  - Latency: data_o and sample_tick_o assert 1 clock after sample_tick_i. sample_tick_o is a 1-clock pulse.
- gain_o, muted_o and state_o are registered and update in the same clock as the state.
- muted_o = 1 exactly while state is CLOSED.
- Silence flag toggling every tick must never wedge the FSM. Each state always has a defined exit.
- Illegal state encodings recover to OPEN on the next clock.

Test Plan:
- Reset mid-fade: assert rst_i asynchronously during FADE_OUT with gain=127 -> immediately state_o=0, gain_o=255, data_o=0, muted_o=0.
- Full close, with HOLD_SAMPLES=4, RAMP_STEP=64, silence_i held 1 -> 4 ticks in HOLD, then gain_o 191,127,63,0. muted_o=1 on the tick gain reaches 0; state_o=3.
- Reopen from CLOSED: silence_i=0 -> FADE_IN, gain_o 64,128,192,255. state_o=0 after the 4th tick. silence_i=1 pulses during the ramp have no effect.
- Short silence: silence_i=1 for 3 ticks with HOLD_SAMPLES=4 -> returns to OPEN, gain_o stays 255, data_o==data_i throughout.
- Datapath, gain=127: data_i=1000 -> data_o=496; data_i=-1000 -> data_o=-497; data_i=-32768 -> data_o=-16256. Each appears 1 clock after its tick with sample_tick_o=1.
- Enable override: enable_i 1->0 while CLOSED, no tick -> next clock state_o=0, gain_o=255, muted_o=0. The following tick gives data_o=data_i.

Source files
------------

// File: rtl/silence_gate_ctrl.sv
// Noise-gate controller: turns the detector's silence flag into a hold / fade-out /
// closed / fade-in gain sequence and applies that gain to the sample stream.
module silence_gate_ctrl #(
  parameter int DW           = 16,
  parameter int GAIN_W       = 8,
  parameter int HOLD_SAMPLES = 4410,
  parameter int RAMP_STEP    = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     sample_tick_i,
  input  logic                     enable_i,
  input  logic                     silence_i,
  input  logic signed [DW-1:0]     data_i,
  output logic signed [DW-1:0]     data_o,
  output logic                     sample_tick_o,
  output logic [GAIN_W-1:0]        gain_o,
  output logic                     muted_o,
  output logic [2:0]               state_o
);

  localparam int PW = DW + GAIN_W;
  localparam logic [GAIN_W-1:0] GMAX      = '1;
  localparam logic [GAIN_W-1:0] STEP      = GAIN_W'(RAMP_STEP);
  localparam logic [15:0]       HOLD_LAST = 16'(HOLD_SAMPLES - 1);

  typedef enum logic [2:0] {
    S_OPEN     = 3'd0,
    S_HOLD     = 3'd1,
    S_FADE_OUT = 3'd2,
    S_CLOSED   = 3'd3,
    S_FADE_IN  = 3'd4
  } state_t;

  state_t              state;
  logic [GAIN_W-1:0]   gain;
  logic [15:0]         cnt;
  logic                muted;
  logic                state_legal;
  logic signed [PW-1:0] prod;

  assign state_o     = state;
  assign gain_o      = gain;
  assign muted_o     = muted;
  assign state_legal = (state <= S_FADE_IN);

  // Disable and illegal encodings act on every clock, not only on sample ticks.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_OPEN;
      gain  <= GMAX;
      cnt   <= '0;
      muted <= 1'b0;
    end else if (!enable_i || !state_legal) begin
      state <= S_OPEN;
      gain  <= GMAX;
      cnt   <= '0;
      muted <= 1'b0;
    end else if (sample_tick_i) begin
      case (state)
        S_OPEN: begin
          gain  <= GMAX;
          muted <= 1'b0;
          if (silence_i) begin
            state <= S_HOLD;
            cnt   <= '0;
          end
        end
        S_HOLD: begin
          if (!silence_i)             state <= S_OPEN;
          else if (cnt == HOLD_LAST)  state <= S_FADE_OUT;
          else                        cnt   <= cnt + 16'd1;
        end
        S_FADE_OUT: begin
          if (!silence_i) begin
            state <= S_FADE_IN;
          end else if (gain <= STEP) begin
            gain  <= '0;
            state <= S_CLOSED;
            muted <= 1'b1;
          end else begin
            gain <= gain - STEP;
          end
        end
        S_CLOSED: begin
          gain <= '0;
          if (!silence_i) begin
            state <= S_FADE_IN;
            muted <= 1'b0;
          end
        end
        S_FADE_IN: begin
          if (gain >= GMAX - STEP) begin
            gain  <= GMAX;
            state <= S_OPEN;
          end else begin
            gain <= gain + STEP;
          end
        end
        default: begin
          state <= S_OPEN;
          gain  <= GMAX;
          cnt   <= '0;
          muted <= 1'b0;
        end
      endcase
    end
  end

  // Product of signed sample and unsigned gain always fits in DW+GAIN_W bits.
  assign prod = PW'(data_i) * $signed(PW'(gain));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_o        <= '0;
      sample_tick_o <= 1'b0;
    end else begin
      sample_tick_o <= sample_tick_i;
      if (sample_tick_i) begin
        if (!enable_i || gain == GMAX) data_o <= data_i;
        else                           data_o <= DW'(prod >>> GAIN_W);
      end
    end
  end

endmodule

// File: tb/tb_silence_gate_ctrl.sv
// Directed bench for silence_gate_ctrl with HOLD_SAMPLES=4, RAMP_STEP=64.
module tb_silence_gate_ctrl;

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b1;
  logic               sample_tick_i = 1'b0;
  logic               enable_i = 1'b1;
  logic               silence_i = 1'b0;
  logic signed [15:0] data_i = '0;
  logic signed [15:0] data_o;
  logic               sample_tick_o;
  logic [7:0]         gain_o;
  logic               muted_o;
  logic [2:0]         state_o;

  int tests = 0;
  int fails = 0;

  silence_gate_ctrl #(
    .DW(16), .GAIN_W(8), .HOLD_SAMPLES(4), .RAMP_STEP(64)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .sample_tick_i(sample_tick_i),
    .enable_i(enable_i), .silence_i(silence_i), .data_i(data_i),
    .data_o(data_o), .sample_tick_o(sample_tick_o), .gain_o(gain_o),
    .muted_o(muted_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One sample tick; outputs are sampled 1ns after the active edge.
  task automatic tick(input logic sil, input logic signed [15:0] d);
    @(negedge clk_i);
    sample_tick_i = 1'b1;
    silence_i     = sil;
    data_i        = d;
    @(posedge clk_i);
    #1;
    sample_tick_i = 1'b0;
  endtask

  task automatic idle_clk();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_sg(input string tag, input logic [2:0] st, input logic [7:0] g);
    chk({tag, "_state"}, 32'(state_o), 32'(st));
    chk({tag, "_gain"},  32'(gain_o),  32'(g));
  endtask

  initial begin
    repeat (2) @(posedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    chk("rst_state", 32'(state_o), 0);
    chk("rst_gain", 32'(gain_o), 255);
    chk("rst_data", 32'(data_o), 0);
    chk("rst_muted", 32'(muted_o), 0);
    chk("rst_tick", 32'(sample_tick_o), 0);

    // Short silence: three ticks stay in HOLD, gain and data untouched.
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 16'(100 + i));
      chk_sg("short_hold", 3'd1, 8'd255);
      chk("short_data", 32'(data_o), 32'(100 + i));
      chk("short_tick", 32'(sample_tick_o), 1);
    end
    tick(1'b0, -16'sd200);
    chk_sg("short_open", 3'd0, 8'd255);
    chk("short_data_neg", 32'(data_o), -200);
    idle_clk();
    chk("tick_pulse_low", 32'(sample_tick_o), 0);

    // Full close: 4 ticks in HOLD, entry to FADE_OUT, then 191,127,63,0.
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 16'sd300);
      chk_sg("close_hold", 3'd1, 8'd255);
    end
    tick(1'b1, 16'sd300);
    chk_sg("close_enter_fade", 3'd2, 8'd255);
    tick(1'b1, 16'sd1000);
    chk_sg("close_g191", 3'd2, 8'd191);
    chk("close_data_g255", 32'(data_o), 1000);
    tick(1'b1, 16'sd1000);
    chk_sg("close_g127", 3'd2, 8'd127);
    chk("close_data_g191", 32'(data_o), 746);
    tick(1'b1, 16'sd1000);
    chk_sg("close_g63", 3'd2, 8'd63);
    chk("dp_g127_pos", 32'(data_o), 496);
    chk("dp_g127_pos_tick", 32'(sample_tick_o), 1);
    chk("close_muted_pre", 32'(muted_o), 0);
    tick(1'b1, 16'sd1000);
    chk_sg("close_g0", 3'd3, 8'd0);
    chk("close_muted", 32'(muted_o), 1);
    tick(1'b1, 16'sd1000);
    chk_sg("closed_stay", 3'd3, 8'd0);
    chk("closed_data", 32'(data_o), 0);

    // Reopen: silence pulses during FADE_IN are ignored.
    tick(1'b0, 16'sd500);
    chk_sg("reopen_enter", 3'd4, 8'd0);
    chk("reopen_unmuted", 32'(muted_o), 0);
    tick(1'b1, 16'sd500);
    chk_sg("reopen_g64", 3'd4, 8'd64);
    tick(1'b0, 16'sd500);
    chk_sg("reopen_g128", 3'd4, 8'd128);
    tick(1'b1, 16'sd500);
    chk_sg("reopen_g192", 3'd4, 8'd192);
    tick(1'b1, 16'sd500);
    chk_sg("reopen_open", 3'd0, 8'd255);
    chk("reopen_data_g192", 32'(data_o), 375);

    // Back to gain 127, then abort the fade to hold 127 for two more samples.
    repeat (5) tick(1'b1, 16'sd0);
    chk_sg("fade2_enter", 3'd2, 8'd255);
    tick(1'b1, 16'sd0);
    tick(1'b1, 16'sd0);
    chk_sg("fade2_g127", 3'd2, 8'd127);
    tick(1'b0, -16'sd1000);
    chk_sg("abort_fade", 3'd4, 8'd127);
    chk("dp_g127_neg", 32'(data_o), -497);
    tick(1'b0, -16'sd32768);
    chk_sg("fadein_g191", 3'd4, 8'd191);
    chk("dp_g127_min", 32'(data_o), -16256);
    tick(1'b1, 16'sd0);
    chk_sg("fadein_open", 3'd0, 8'd255);

    // Asynchronous reset in the middle of a fade, away from any clock edge.
    repeat (7) tick(1'b1, 16'sd1000);
    chk_sg("fade3_g127", 3'd2, 8'd127);
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_state", 32'(state_o), 0);
    chk("arst_gain", 32'(gain_o), 255);
    chk("arst_data", 32'(data_o), 0);
    chk("arst_muted", 32'(muted_o), 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Enable override from CLOSED without a sample tick.
    repeat (9) tick(1'b1, 16'sd0);
    chk_sg("en_closed", 3'd3, 8'd0);
    chk("en_closed_muted", 32'(muted_o), 1);
    @(negedge clk_i);
    enable_i  = 1'b0;
    silence_i = 1'b1;
    idle_clk();
    chk_sg("en_off", 3'd0, 8'd255);
    chk("en_off_muted", 32'(muted_o), 0);
    tick(1'b1, 16'sd1234);
    chk("en_off_data", 32'(data_o), 1234);
    chk_sg("en_off_stay", 3'd0, 8'd255);
    enable_i = 1'b1;

    // Rapid silence toggling never wedges the FSM.
    for (int i = 0; i < 20; i++) tick(1'(i % 2), 16'sd7);
    tick(1'b0, 16'sd7);
    chk_sg("toggle_open", 3'd0, 8'd255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
